// File: rtl/a10_sata_fpll_recal_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : a10_sata_fpll_recal_ctrl_if
// Function : Avalon-MM reconfiguration bus between recal controller and fPLL
// Revision : 1.0
// ============================================================================
interface a10_sata_fpll_recal_ctrl_if;
  logic [9:0]  reconfig_address;
  logic        reconfig_write;
  logic        reconfig_read;
  logic [31:0] reconfig_writedata;
  logic [31:0] reconfig_readdata;
  logic        reconfig_waitrequest;

  modport master (
    output reconfig_address,
    output reconfig_write,
    output reconfig_read,
    output reconfig_writedata,
    input  reconfig_readdata,
    input  reconfig_waitrequest
  );

  modport slave (
    input  reconfig_address,
    input  reconfig_write,
    input  reconfig_read,
    input  reconfig_writedata,
    output reconfig_readdata,
    output reconfig_waitrequest
  );
endinterface
`default_nettype wire

// File: rtl/a10_sata_fpll_recal_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : a10_sata_fpll_recal_ctrl
// Function : Arria 10 SATA fPLL user recalibration sequencer (Avalon-MM master)
// Revision : 1.0
// ============================================================================
module a10_sata_fpll_recal_ctrl #(
  parameter logic [9:0] ARB_ADDR  = 10'h000,
  parameter logic [9:0] CAL_ADDR  = 10'h100,
  parameter int unsigned CAL_BIT  = 1,
  parameter logic [9:0] STAT_ADDR = 10'h280,
  parameter int unsigned STAT_BIT = 1,
  parameter int unsigned TIMEOUT  = 1000000,
  parameter int unsigned TW       = 20
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  recal_req,
  output logic recal_busy,
  output logic recal_done,
  output logic recal_error,
  input  wire  pll_cal_busy,
  a10_sata_fpll_recal_ctrl_if.master reconfig
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ARB_WR  = 4'd1,
    S_POLL_RD = 4'd2,
    S_CAL_RD  = 4'd3,
    S_CAL_WR  = 4'd4,
    S_REL_WR  = 4'd5,
    S_WAIT_HI = 4'd6,
    S_WAIT_LO = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam logic [TW-1:0] C_TMO      = TW'(TIMEOUT);
  localparam logic [31:0]   C_CAL_MASK = 32'(1) << CAL_BIT;
  localparam logic [31:0]   C_ARB_REQ  = 32'h0000_0002;
  localparam logic [31:0]   C_ARB_REL  = 32'h0000_0001;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [9:0]    addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          xfer_done;
  logic          cnt_sat;
  logic [TW-1:0] cnt_inc;

  assign xfer_done = (rd_q | wr_q) & ~reconfig.reconfig_waitrequest;
  assign cnt_sat   = (cnt_q == C_TMO);
  assign cnt_inc   = cnt_sat ? cnt_q : cnt_q + 1'b1;

  // Bus states: a strobe is raised only from a cycle where no strobe is up,
  // so dropping it on completion always leaves one idle cycle between transfers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (recal_req) begin
          state_d = S_ARB_WR;
          err_d   = 1'b0;
          cnt_d   = '0;
          addr_d  = ARB_ADDR;
          wdata_d = C_ARB_REQ;
          wr_d    = 1'b1;
        end
      end
      S_ARB_WR: begin
        if (!wr_q) begin
          addr_d  = ARB_ADDR;
          wdata_d = C_ARB_REQ;
          wr_d    = 1'b1;
        end else if (xfer_done) begin
          wr_d    = 1'b0;
          state_d = S_POLL_RD;
        end
      end
      S_POLL_RD: begin
        cnt_d = cnt_inc;
        if (!rd_q) begin
          addr_d = STAT_ADDR;
          rd_d   = 1'b1;
        end else if (xfer_done) begin
          rd_d = 1'b0;
          if (!reconfig.reconfig_readdata[STAT_BIT]) begin
            state_d = S_CAL_RD;
          end else if (cnt_sat) begin
            err_d   = 1'b1;
            state_d = S_REL_WR;
          end
        end
      end
      S_CAL_RD: begin
        if (!rd_q) begin
          addr_d = CAL_ADDR;
          rd_d   = 1'b1;
        end else if (xfer_done) begin
          rd_d     = 1'b0;
          shadow_d = reconfig.reconfig_readdata;
          state_d  = S_CAL_WR;
        end
      end
      S_CAL_WR: begin
        if (!wr_q) begin
          addr_d  = CAL_ADDR;
          wdata_d = shadow_q | C_CAL_MASK;
          wr_d    = 1'b1;
        end else if (xfer_done) begin
          wr_d    = 1'b0;
          state_d = S_REL_WR;
        end
      end
      S_REL_WR: begin
        if (!wr_q) begin
          addr_d  = ARB_ADDR;
          wdata_d = C_ARB_REL;
          wr_d    = 1'b1;
        end else if (xfer_done) begin
          wr_d = 1'b0;
          if (err_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_HI;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_HI: begin
        if (pll_cal_busy) begin
          state_d = S_WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_sat) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LO: begin
        if (!pll_cal_busy) begin
          state_d = S_DONE;
        end else if (cnt_sat) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign recal_busy                  = busy_q;
  assign recal_done                  = done_q;
  assign recal_error                 = err_q;
  assign reconfig.reconfig_address   = addr_q;
  assign reconfig.reconfig_read      = rd_q;
  assign reconfig.reconfig_write     = wr_q;
  assign reconfig.reconfig_writedata = wdata_q;

endmodule
`default_nettype wire

// File: doc/a10_sata_fpll_recal_ctrl.md
Name: a10_sata_fpll_recal_ctrl

Overview:
- Avalon-MM master driving the reconfiguration slave port of the SATA transceiver fPLL.
- On request, runs the Arria 10 fPLL user recalibration sequence: acquire internal config bus, poll for grant, read-modify-write the calibration enable bit, return the bus to PreSICE, then track pll_cal_busy to completion.
- Sits between the SATA link reset/rate-change controller and the fPLL core, on the reconfig clock domain.

Parameters:
- ARB_ADDR, 10'h000, bus arbitration register address
- CAL_ADDR, 10'h100, calibration enable register address
- CAL_BIT, 1, bit index in CAL_ADDR that starts fPLL calibration
- STAT_ADDR, 10'h280, capability/status register address polled for bus grant
- STAT_BIT, 1, bit in STAT_ADDR; 0 = bus granted to user
- TIMEOUT, 1000000, clk cycles allowed for each wait phase (grant poll, busy rise, busy fall)
- TW, 20, width of timeout counter; must satisfy 2^TW > TIMEOUT

Ports:
- clk  in  1  reconfig clock
- reset  in  1  synchronous active-high reset
- recal_req  in  1  start pulse; sampled only in IDLE
- recal_busy  out  1  high while a sequence is in progress
- recal_done  out  1  one-cycle pulse at sequence end
- recal_error  out  1  sticky timeout flag; cleared by the next accepted recal_req or by reset
- pll_cal_busy  in  1  fPLL calibration busy, already synchronous to clk
- reconfig_address  out  10  Avalon address
- reconfig_write  out  1  Avalon write
- reconfig_read  out  1  Avalon read
- reconfig_writedata  out  32  Avalon write data
- reconfig_readdata  in  32  Avalon read data; valid in the cycle where read && !waitrequest
- reconfig_waitrequest  in  1  Avalon waitrequest

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; timeout counter 0; shadow register 0.
  - Reset mid-transfer drops read/write on the next edge; no transaction completion is tracked after reset.
- Avalon rules:
  - Address, read, write and writedata are registered and held constant while waitrequest=1.
  - A transfer completes in the cycle where (read|write) && !waitrequest; the strobe deasserts on the following edge.
  - read and write are never both high.
  - At least one idle cycle between consecutive transfers.
- States and transitions:
  - IDLE: recal_req=1 -> ARB_WR; recal_busy<=1, recal_error<=0, counter<=0.
  - ARB_WR: write 32'h2 to ARB_ADDR (request bus) -> POLL_RD on completion.
  - POLL_RD: read STAT_ADDR. On completion:
    - readdata[STAT_BIT]=0 -> CAL_RD.
    - otherwise, if counter==TIMEOUT -> set error, go REL_WR; else re-issue the read.
    - Counter increments every cycle in POLL_RD.
  - CAL_RD: read CAL_ADDR; capture readdata into shadow -> CAL_WR.
  - CAL_WR: write shadow with bit CAL_BIT forced 1, all other bits preserved -> REL_WR.
  - REL_WR: write 32'h1 to ARB_ADDR (release bus to PreSICE). Then:
    - error set -> DONE.
    - error clear -> WAIT_HI, counter<=0.
  - WAIT_HI: pll_cal_busy=1 -> WAIT_LO, counter<=0; counter==TIMEOUT -> error, DONE.
  - WAIT_LO: pll_cal_busy=0 -> DONE; counter==TIMEOUT -> error, DONE.
  - DONE: recal_done=1 for one cycle, recal_busy<=0 -> IDLE.
- Boundary conditions:
  - recal_req while busy is ignored (not queued).
  - recal_req in the same cycle as DONE is ignored.
  - A recal_req held high restarts the sequence on the cycle after returning to IDLE.
  - Counter saturates at TIMEOUT; it never wraps.
  - pll_cal_busy already high when WAIT_HI is entered counts as the rise.
  - The bus is always released, even after a grant timeout.
- Latency (waitrequest=0, grant on first poll, busy responds immediately): recal_done 11 cycles after recal_req is accepted, ±1 per extra idle cycle.

Test Plan:
- Nominal:
  - Stimulus: waitrequest tied 0; STAT bit 0 on first read; CAL readdata 32'hA5; pll_cal_busy high 50 cycles after release.
  - Required: writes in order 000<=2, 100<=A7, 000<=1; recal_done pulses once; recal_error=0.
- Waitrequest stretch:
  - Stimulus: random waitrequest 0-7 cycles per transfer.
  - Required: address/data/strobes stable during stretch; same three writes; one read of 280 and one of 100.
- Grant poll:
  - Stimulus: STAT bit 1 for 5 reads then 0.
  - Required: exactly 6 reads of 280 before the CAL read.
- Grant timeout:
  - Stimulus: TIMEOUT=100; STAT bit stuck 1.
  - Required: recal_error=1; release write 000<=1 issued; no write to 100; recal_done pulses.
- Busy timeout:
  - Stimulus: TIMEOUT=100; pll_cal_busy never rises.
  - Required: recal_error=1 at 100 cycles after release; recal_done pulses.
  - Then a new recal_req clears recal_error.
- Reset and request handling:
  - Stimulus: reset asserted during CAL_WR with waitrequest=1.
  - Required: all outputs 0 next cycle; recal_req pulsed during busy produces no second sequence.
